// File: rtl/block_backing_mem.sv
// -----------------------------------------------------------------------------
// block_backing_mem
//
// Block-granular main-memory model for the level below the last cache. It
// accepts one miss request, waits a fixed number of clock edges, then performs
// the block read or write and pulses requestComplete for one cycle. Contents
// are deterministic: at power-up the byte at byte address a holds a[7:0], with
// byte 0 of a block in bits [7:0]. Reset never touches the array.
//
// Parameters
//   ADDR_LENGTH  byte-address width
//   BLOCK_SIZE   block width in bits (multiple of 8, power of two)
//   DELAY        edges from the accepting edge to requestComplete (>= 2)
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low; clears all state except the array
//   enable           request strobe, level-sampled while idle
//   addr             byte address; the byte-select bits are ignored
//   we               1 = write data_in to the block, 0 = read
//   data_in          write data
//   data_out         returned block (read data, or the written data echoed)
//   requestComplete  one-cycle completion pulse
//   busy             high from acceptance until enable is released after completion
//
// Optional build macro BLOCK_MEM_STATS_EN adds saturating 16-bit read_count and
// write_count outputs, incremented on each completed access of that type.
// -----------------------------------------------------------------------------
module block_backing_mem #(
  parameter int ADDR_LENGTH = 10,
  parameter int BLOCK_SIZE  = 32,
  parameter int DELAY       = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [ADDR_LENGTH-1:0] addr,
  input  logic                   we,
  input  logic [BLOCK_SIZE-1:0]  data_in,
  output logic [BLOCK_SIZE-1:0]  data_out,
  output logic                   requestComplete,
  output logic                   busy
`ifdef BLOCK_MEM_STATS_EN
  ,
  output logic [15:0]            read_count,
  output logic [15:0]            write_count
`endif
);

  localparam int BYTES = BLOCK_SIZE / 8;
  localparam int BSEL  = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = ADDR_LENGTH - BSEL;
  localparam int DEPTH = 1 << IDX_W;
  localparam int CNT_W = $clog2(DELAY + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Power-on contents of one block: each byte equals the low 8 bits of its
  // own byte address.
  function automatic logic [BLOCK_SIZE-1:0] init_block(input logic [IDX_W-1:0] idx);
    logic [BLOCK_SIZE-1:0]  blk;
    logic [ADDR_LENGTH-1:0] base;
    blk  = '0;
    base = ADDR_LENGTH'(idx) << BSEL;
    for (int j = 0; j < BYTES; j++) begin
      blk[j*8 +: 8] = 8'(base + ADDR_LENGTH'(j));
    end
    return blk;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  we_q, we_d;
  logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
  logic [BLOCK_SIZE-1:0] data_out_q, data_out_d;
  logic                  rc_q, rc_d;
`ifdef BLOCK_MEM_STATS_EN
  logic [15:0]           read_cnt_q, read_cnt_d;
  logic [15:0]           write_cnt_q, write_cnt_d;
`endif

  // Each word is stored XORed with its power-on pattern, so an array that
  // powers up all-zero (FPGA block RAM, two-state simulation) reads back the
  // required initial contents without an init sweep or a reset.
  logic [BLOCK_SIZE-1:0] mem_q [DEPTH];
  logic [BLOCK_SIZE-1:0] rd_block;

  assign rd_block = mem_q[idx_q] ^ init_block(idx_q);

  // The byte-select bits of addr carry no information for a block memory.
  generate
    if (BSEL > 0) begin : g_unused_bsel
      logic unused_bsel;
      assign unused_bsel = ^addr[BSEL-1:0];
    end
  endgenerate

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case
    // leaves one unassigned and infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    rc_d       = rc_q;
`ifdef BLOCK_MEM_STATS_EN
    read_cnt_d  = read_cnt_q;
    write_cnt_d = write_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          idx_d   = addr[ADDR_LENGTH-1:BSEL];
          we_d    = we;
          wdata_d = data_in;
          cnt_d   = CNT_W'(1);
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Inputs are deliberately ignored here; the request was captured at
        // acceptance.
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DELAY - 1)) begin
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        data_out_d = we_q ? wdata_q : rd_block;
        rc_d       = 1'b1;
        state_d    = ST_HOLD;
`ifdef BLOCK_MEM_STATS_EN
        if (we_q) begin
          if (write_cnt_q != 16'hFFFF) write_cnt_d = write_cnt_q + 16'd1;
        end else begin
          if (read_cnt_q != 16'hFFFF) read_cnt_d = read_cnt_q + 16'd1;
        end
`endif
      end

      ST_HOLD: begin
        // Waiting for enable to drop keeps a level-held miss line from
        // launching a second access.
        rc_d = 1'b0;
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      data_out_q <= '0;
      rc_q       <= 1'b0;
`ifdef BLOCK_MEM_STATS_EN
      read_cnt_q  <= '0;
      write_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      rc_q       <= rc_d;
`ifdef BLOCK_MEM_STATS_EN
      read_cnt_q  <= read_cnt_d;
      write_cnt_q <= write_cnt_d;
`endif
    end
  end

  // NOTE: the array has no reset on purpose; contents survive reset and the
  // block maps onto plain RAM. Reset forces the FSM out of ACCESS, so an
  // in-flight write is dropped; the extra reset term covers an edge that
  // coincides with reset assertion.
  always_ff @(posedge clk) begin
    if (reset && (state_q == ST_ACCESS) && we_q) begin
      mem_q[idx_q] <= wdata_q ^ init_block(idx_q);
    end
  end

  assign data_out        = data_out_q;
  assign requestComplete = rc_q;
  assign busy            = (state_q != ST_IDLE);
`ifdef BLOCK_MEM_STATS_EN
  assign read_count  = read_cnt_q;
  assign write_count = write_cnt_q;
`endif

endmodule
